// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch slice: word and address widths,
// the halt word that terminates a program, and the fetch state encoding.
package cpu_pkg;

  localparam int unsigned INSTRUCTION_WIDTH = 32;
  localparam int unsigned ADDRESS_WIDTH     = 8;
  localparam int unsigned DEPTH             = 2 ** ADDRESS_WIDTH;

  typedef logic [INSTRUCTION_WIDTH-1:0] instruction_t;
  typedef logic [ADDRESS_WIDTH-1:0]     address_t;

  localparam instruction_t HALT_INSTRUCTION = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    FETCH_IDLE,
    FETCH_RUN,
    FETCH_HALTED
  } fetch_state_t;

endpackage

// File: rtl/instruction_memory.sv
// Program memory: DEPTH x INSTRUCTION_WIDTH, one write port, one synchronous read
// port with a single cycle of latency. Contents are never reset.
//   clock_in          clock, posedge
//   write_enable_in   write strobe
//   write_address_in  write address
//   write_data_in     write data
//   read_enable_in    read strobe; read_data_out updates only when set
//   read_address_in   read address
//   read_data_out     word read on the previous enabled edge
module instruction_memory
  import cpu_pkg::*;
(
  input  logic         clock_in,
  input  logic         write_enable_in,
  input  address_t     write_address_in,
  input  instruction_t write_data_in,
  input  logic         read_enable_in,
  input  address_t     read_address_in,
  output instruction_t read_data_out
);

  instruction_t memory [DEPTH];
  instruction_t read_data_q;

  always_ff @(posedge clock_in) begin
    if (write_enable_in) begin
      memory[write_address_in] <= write_data_in;
    end
    if (read_enable_in) begin
      read_data_q <= memory[read_address_in];
    end
  end

  assign read_data_out = read_data_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: holds program memory, runs the PC and streams one
// instruction per cycle to the core over a valid/ready handshake.
//   clock_in               clock, all logic on posedge
//   reset_in               synchronous active-high reset
//   start_in               begin fetching at address 0 (from idle or halted)
//   load_enable_in         program write strobe, honoured only while idle
//   load_address_in        program write address
//   load_data_in           program write data
//   jump_in                redirect request from the core (running only)
//   jump_target_in         redirect address
//   ready_in               downstream accepts the presented instruction
//   instruction_out        presented instruction
//   instruction_valid_out  instruction_out is valid
//   pc_out                 address of the presented instruction
//   halted_out             halt word reached, fetch stopped
// Pipeline: pc -> memory read register (rd) -> output register, with a one-entry
// skid buffer catching the in-flight read while the output is stalled.
module instruction_fetch_unit
  import cpu_pkg::*;
(
  input  logic         clock_in,
  input  logic         reset_in,
  input  logic         start_in,
  input  logic         load_enable_in,
  input  address_t     load_address_in,
  input  instruction_t load_data_in,
  input  logic         jump_in,
  input  address_t     jump_target_in,
  input  logic         ready_in,
  output instruction_t instruction_out,
  output logic         instruction_valid_out,
  output address_t     pc_out,
  output logic         halted_out
);

  fetch_state_t state_q, state_d;
  address_t     pc_q, pc_d;
  logic         rd_valid_q, rd_valid_d;
  address_t     rd_pc_q, rd_pc_d;
  logic         skid_valid_q, skid_valid_d;
  instruction_t skid_q, skid_d;
  address_t     skid_pc_q, skid_pc_d;
  logic         out_valid_q, out_valid_d;
  instruction_t out_q, out_d;
  address_t     out_pc_q, out_pc_d;
  logic         halted_q, halted_d;

  instruction_t read_data;
  logic         running;
  logic         stall;
  logic         read_enable;
  logic         src_valid;
  instruction_t src_word;
  address_t     src_pc;

  assign running     = (state_q == FETCH_RUN);
  assign stall       = out_valid_q && !ready_in;
  assign read_enable = running && !stall && !jump_in;

  // The skid entry is older than anything in the read register, so it drains first.
  assign src_valid = skid_valid_q || rd_valid_q;
  assign src_word  = skid_valid_q ? skid_q : read_data;
  assign src_pc    = skid_valid_q ? skid_pc_q : rd_pc_q;

  instruction_memory u_instruction_memory (
    .clock_in         (clock_in),
    .write_enable_in  (load_enable_in && (state_q == FETCH_IDLE)),
    .write_address_in (load_address_in),
    .write_data_in    (load_data_in),
    .read_enable_in   (read_enable),
    .read_address_in  (pc_q),
    .read_data_out    (read_data)
  );

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    rd_valid_d   = rd_valid_q;
    rd_pc_d      = rd_pc_q;
    skid_valid_d = skid_valid_q;
    skid_d       = skid_q;
    skid_pc_d    = skid_pc_q;
    out_valid_d  = out_valid_q;
    out_d        = out_q;
    out_pc_d     = out_pc_q;
    halted_d     = halted_q;

    unique case (state_q)
      FETCH_IDLE, FETCH_HALTED: begin
        if (start_in) begin
          state_d  = FETCH_RUN;
          pc_d     = '0;
          halted_d = 1'b0;
        end
      end

      FETCH_RUN: begin
        if (jump_in) begin
          // Redirect wins over backpressure and halt detection.
          pc_d         = jump_target_in;
          rd_valid_d   = 1'b0;
          skid_valid_d = 1'b0;
          out_valid_d  = 1'b0;
        end else if (stall) begin
          // Park the in-flight read; no new read is issued while stalled.
          if (rd_valid_q) begin
            skid_valid_d = 1'b1;
            skid_d       = read_data;
            skid_pc_d    = rd_pc_q;
          end
          rd_valid_d = 1'b0;
        end else begin
          rd_valid_d   = 1'b1;
          rd_pc_d      = pc_q;
          pc_d         = pc_q + 1'b1;
          skid_valid_d = 1'b0;
          if (src_valid && (src_word == HALT_INSTRUCTION)) begin
            // Halt word is swallowed; anything still in flight is dropped.
            state_d     = FETCH_HALTED;
            halted_d    = 1'b1;
            out_valid_d = 1'b0;
            rd_valid_d  = 1'b0;
          end else begin
            out_valid_d = src_valid;
            if (src_valid) begin
              out_d    = src_word;
              out_pc_d = src_pc;
            end
          end
        end
      end

      default: state_d = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clock_in) begin
    if (reset_in) begin
      state_q      <= FETCH_IDLE;
      pc_q         <= '0;
      rd_valid_q   <= 1'b0;
      rd_pc_q      <= '0;
      skid_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_pc_q    <= '0;
      out_valid_q  <= 1'b0;
      out_q        <= '0;
      out_pc_q     <= '0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      rd_valid_q   <= rd_valid_d;
      rd_pc_q      <= rd_pc_d;
      skid_valid_q <= skid_valid_d;
      skid_q       <= skid_d;
      skid_pc_q    <= skid_pc_d;
      out_valid_q  <= out_valid_d;
      out_q        <= out_d;
      out_pc_q     <= out_pc_d;
      halted_q     <= halted_d;
    end
  end

  assign instruction_out       = out_q;
  assign instruction_valid_out = out_valid_q;
  assign pc_out                = out_pc_q;
  assign halted_out            = halted_q;

endmodule
